state_dispatch: RTL
===================

STATE_DISPATCH -- requirements
Module: state_dispatch

Interface
REQ-001 SHALL have parameter ADDR_W, default 12, meaning state-entry index and parameter-address width.
REQ-002 SHALL have parameter POS_W, default 5, meaning recursion execution-position width.
REQ-003 SHALL have parameter DATA_W, default 18, meaning state word width; layout is [17] done flag, [16:12] position, [11:0] parameter address.
REQ-004 SHALL have port clk  input  1  single clock; all flops rise-edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port start  input  1  one-cycle pulse that begins a dispatch run.
REQ-007 SHALL have port num_states  input  ADDR_W  count of valid state entries, sampled on start.
REQ-008 SHALL have port seq_re  output  1  sequential read pulse to the state regfile.
REQ-009 SHALL have ports st_addr  input  ADDR_W  and st_data  input  DATA_W  regfile read-back index and word.
REQ-010 SHALL have ports disp_valid  output  1, disp_ready  input  1, disp_addr  output  ADDR_W, disp_pos  output  POS_W, disp_idx  output  ADDR_W  dispatch channel to the recursion engine.
REQ-011 SHALL have ports busy  output  1, done  output  1 (one-cycle pulse), pass_cnt  output  8  (passes completed in current run).

Function
REQ-012 SHALL implement FSM states IDLE, RD, CHK, DISP, NEXT, FIN.
REQ-013 IDLE: start=1 SHALL latch num_states, clear index and pass_cnt, go to RD; with num_states=0, go directly to FIN.
REQ-014 RD: SHALL assert seq_re for exactly one cycle, then go to CHK; read data is valid in CHK (one-cycle read latency).
REQ-015 CHK: st_data[17]=1 SHALL skip to NEXT; otherwise SHALL register addr/pos/st_addr into disp_* and go to DISP, setting a pass-live flag.
REQ-016 DISP: SHALL hold disp_valid=1 and disp_* stable until disp_ready=1; the transfer occurs on the cycle both are high, then go to NEXT.
REQ-017 NEXT: index < num_states-1 SHALL increment index and go to RD; at the last index, SHALL increment pass_cnt (saturating at 255) and go to RD with index 0 if the pass-live flag is set, else go to FIN; the flag SHALL clear at each pass start.
REQ-018 FIN: SHALL pulse done for one cycle and return to IDLE.
REQ-019 busy SHALL be 1 in every state except IDLE.
REQ-020 start asserted while busy=1 SHALL be ignored.
REQ-021 seq_re and disp_valid SHALL never be high in the same cycle.
REQ-022 disp_ready while disp_valid=0 SHALL have no effect.
REQ-023 Index arithmetic SHALL be ADDR_W-bit unsigned; num_states=2^ADDR_W-1 SHALL be handled without wrap.

Reset
REQ-024 rst_n=0 SHALL asynchronously force IDLE, seq_re=0, disp_valid=0, disp_addr/pos/idx=0, busy=0, done=0, pass_cnt=0, index=0.
REQ-025 Reset mid-run SHALL abandon the run with no done pulse and no pending dispatch.

Configuration
REQ-026 With macro STATE_DISPATCH_STAT_EN defined, SHALL add output skip_cnt (16 bits) counting done-flag skips in the current run, cleared on start and reset, saturating at 65535.
REQ-027 Without STATE_DISPATCH_STAT_EN, skip_cnt SHALL not exist and behaviour otherwise SHALL be identical.

Verification
REQ-028 start, num_states=0 -> busy for 1 cycle, done pulse, no seq_re, pass_cnt=0.
REQ-029 num_states=3, entries done flag {0,1,0}, pass 2 all done, disp_ready=1 -> dispatch idx 0 then 2, done after pass 2, pass_cnt=2, skip_cnt=4 if enabled.
REQ-030 disp_ready held low 5 cycles in DISP -> disp_valid and disp_addr/pos stable for all 5 cycles, one transfer only.
REQ-031 start pulsed while busy -> no restart, index and pass_cnt unchanged.
REQ-032 rst_n low during DISP -> disp_valid=0 immediately (asynchronously), IDLE after release, no done pulse.
REQ-033 entry word 18'h0_F_ABC (pos=15, addr=12'hABC, done=0) -> disp_pos=15, disp_addr=12'hABC.

Source files
------------

// File: rtl/state_dispatch.sv
// state_dispatch: walks the state regfile in passes and hands live entries to the recursion engine.
// Latency: 3 cycles per done-flagged entry (RD, CHK, NEXT) and 4+ per dispatched entry (RD, CHK, DISP, NEXT).
// Backpressure: DISP holds disp_valid and disp_* until disp_ready; nothing is read meanwhile.
// Optional build macro STATE_DISPATCH_STAT_EN adds the skip_cnt statistic output.
module state_dispatch #(
  parameter int ADDR_W = 12,
  parameter int POS_W  = 5,
  parameter int DATA_W = 18
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] num_states,
  output logic              seq_re,
  input  logic [ADDR_W-1:0] st_addr,
  input  logic [DATA_W-1:0] st_data,
  output logic              disp_valid,
  input  logic              disp_ready,
  output logic [ADDR_W-1:0] disp_addr,
  output logic [POS_W-1:0]  disp_pos,
  output logic [ADDR_W-1:0] disp_idx,
  output logic              busy,
  output logic              done,
  output logic [7:0]        pass_cnt
`ifdef STATE_DISPATCH_STAT_EN
  ,
  output logic [15:0]       skip_cnt
`endif
);

  // State word layout: done flag on top, execution position, then parameter address.
  localparam int DONE_BIT = DATA_W - 1;
  localparam int POS_LSB  = ADDR_W;
  localparam int POS_MSB  = ADDR_W + POS_W - 1;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    CHK  = 3'd2,
    DISP = 3'd3,
    NEXT = 3'd4,
    FIN  = 3'd5
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [ADDR_W-1:0] num_q, num_d;
  logic [7:0]        pass_q, pass_d;
  logic              live_q, live_d;
  logic [ADDR_W-1:0] daddr_q, daddr_d;
  logic [POS_W-1:0]  dpos_q, dpos_d;
  logic [ADDR_W-1:0] didx_q, didx_d;

  // Entry fields decoded from the read-back word (valid only in CHK).
  logic              entry_done;
  logic [POS_W-1:0]  entry_pos;
  logic [ADDR_W-1:0] entry_addr;
  // True while the current index is not the last entry of the pass.
  logic              more_entries;

  assign entry_done   = st_data[DONE_BIT];
  assign entry_pos    = st_data[POS_MSB:POS_LSB];
  assign entry_addr   = st_data[ADDR_W-1:0];
  // num_q is never zero once past IDLE, so num_q-1 cannot underflow and
  // num_states = 2^ADDR_W-1 keeps the last index representable.
  assign more_entries = (idx_q < (num_q - ADDR_W'(1)));

`ifdef STATE_DISPATCH_STAT_EN
  logic [15:0] skip_q, skip_d;
`endif

  // State and datapath registers; reset abandons any run in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      num_q   <= '0;
      pass_q  <= '0;
      live_q  <= 1'b0;
      daddr_q <= '0;
      dpos_q  <= '0;
      didx_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      num_q   <= num_d;
      pass_q  <= pass_d;
      live_q  <= live_d;
      daddr_q <= daddr_d;
      dpos_q  <= dpos_d;
      didx_q  <= didx_d;
    end
  end

`ifdef STATE_DISPATCH_STAT_EN
  // Skip statistic register, cleared on reset and on each accepted start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skip_q <= '0;
    end else begin
      skip_q <= skip_d;
    end
  end

  assign skip_cnt = skip_q;
`endif

  // Next-state and datapath update for the dispatch walk.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    num_d   = num_q;
    pass_d  = pass_q;
    live_d  = live_q;
    daddr_d = daddr_q;
    dpos_d  = dpos_q;
    didx_d  = didx_q;
`ifdef STATE_DISPATCH_STAT_EN
    skip_d  = skip_q;
`endif

    case (state_q)
      IDLE: begin
        // start is only honoured here, so pulses while busy are ignored.
        if (start) begin
          num_d  = num_states;
          idx_d  = '0;
          pass_d = '0;
          live_d = 1'b0;
`ifdef STATE_DISPATCH_STAT_EN
          skip_d = '0;
`endif
          state_d = (num_states == '0) ? FIN : RD;
        end
      end

      RD: begin
        // seq_re is decoded from this state; the word arrives next cycle.
        state_d = CHK;
      end

      CHK: begin
        if (entry_done) begin
`ifdef STATE_DISPATCH_STAT_EN
          if (skip_q != 16'hFFFF) begin
            skip_d = skip_q + 16'd1;
          end
`endif
          state_d = NEXT;
        end else begin
          daddr_d = entry_addr;
          dpos_d  = entry_pos;
          didx_d  = st_addr;
          live_d  = 1'b1;
          state_d = DISP;
        end
      end

      DISP: begin
        if (disp_ready) begin
          state_d = NEXT;
        end
      end

      NEXT: begin
        if (more_entries) begin
          idx_d   = idx_q + ADDR_W'(1);
          state_d = RD;
        end else begin
          if (pass_q != 8'hFF) begin
            pass_d = pass_q + 8'd1;
          end
          // Another pass only if this one dispatched something.
          if (live_q) begin
            idx_d   = '0;
            live_d  = 1'b0;
            state_d = RD;
          end else begin
            state_d = FIN;
          end
        end
      end

      FIN: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Control outputs are pure state decodes, so reset clears them immediately.
  assign seq_re     = (state_q == RD);
  assign disp_valid = (state_q == DISP);
  assign busy       = (state_q != IDLE);
  assign done       = (state_q == FIN);
  assign disp_addr  = daddr_q;
  assign disp_pos   = dpos_q;
  assign disp_idx   = didx_q;
  assign pass_cnt   = pass_q;

endmodule
